// File: rtl/free_list_if.sv
// Rename-stage <-> free list port bundle: allocation requests/grants, commit
// returns, flush and status. master = rename/commit side, slave = free list.
interface free_list_if #(
  parameter int N_WAY    = 3,
  parameter int CDB_BITS = 6,
  parameter int CNT_BITS = 6
);
  localparam int AV_BITS = $clog2(N_WAY + 1);

  logic [N_WAY-1:0]               dis_req;
  logic [N_WAY-1:0][CDB_BITS-1:0] pr_freelist;
  logic [N_WAY-1:0]               pr_valid;
  logic [AV_BITS-1:0]             avail;
  logic [N_WAY-1:0]               retire_valid;
  logic [N_WAY-1:0][CDB_BITS-1:0] retire_pr;
  logic                           flush;
  logic [CNT_BITS-1:0]            free_count;
  logic                           error;

  modport master (
    output dis_req, retire_valid, retire_pr, flush,
    input  pr_freelist, pr_valid, avail, free_count, error
  );

  modport slave (
    input  dis_req, retire_valid, retire_pr, flush,
    output pr_freelist, pr_valid, avail, free_count, error
  );
endinterface

// File: rtl/free_list.sv
// R10K-style physical register free list: circular queue of free tags, N_WAY
// allocs and N_WAY frees per cycle, single-cycle flush recovery by head rewind.
module free_list_lane #(
  parameter int PTR_BITS = 5,
  parameter int CNT_BITS = 6
) (
  input  logic                req_i,
  input  logic                ret_i,
  input  logic [CNT_BITS-1:0] k_i,
  input  logic [CNT_BITS-1:0] j_i,
  input  logic [PTR_BITS-1:0] head_i,
  input  logic [PTR_BITS-1:0] tail_i,
  input  logic [CNT_BITS-1:0] cnt_i,
  input  logic [CNT_BITS-1:0] room_i,
  input  logic                block_i,
  output logic                grant_o,
  output logic [PTR_BITS-1:0] rd_idx_o,
  output logic                wr_en_o,
  output logic [PTR_BITS-1:0] wr_idx_o
);
  // k_i/j_i are the number of active slots below this one in each group
  assign grant_o  = req_i && !block_i && (k_i < cnt_i);
  assign rd_idx_o = head_i + k_i[PTR_BITS-1:0];
  assign wr_en_o  = ret_i && (j_i < room_i);
  assign wr_idx_o = tail_i + j_i[PTR_BITS-1:0];
endmodule

module free_list #(
  parameter int N_WAY      = 3,
  parameter int PR_COUNT   = 64,
  parameter int ARCH_COUNT = 32,
  parameter int CDB_BITS   = $clog2(PR_COUNT)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  free_list_if.slave  fl_if
);
  localparam int D        = PR_COUNT - ARCH_COUNT;
  localparam int PTR_BITS = $clog2(D);
  localparam int CNT_BITS = $clog2(D + 1);
  localparam int AV_BITS  = $clog2(N_WAY + 1);

  logic [D-1:0][CDB_BITS-1:0] entries_q, entries_d;
  logic [PTR_BITS-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CNT_BITS-1:0]        cnt_q, cnt_d;
  logic                       err_q, err_d;

  logic [N_WAY-1:0][CNT_BITS-1:0] k_pre, j_pre;
  logic [N_WAY-1:0][PTR_BITS-1:0] rd_idx, wr_idx;
  logic [N_WAY-1:0]               grant, wr_en;
  logic [CNT_BITS-1:0]            g_cnt, r_cnt, r_eff, room;
  logic                           block;

  // Grants are suppressed while flushing and while reset is held
  assign block = fl_if.flush || !rst_ni;

  always_comb begin
    logic [CNT_BITS-1:0] ka, ja;
    ka    = '0;
    ja    = '0;
    k_pre = '0;
    j_pre = '0;
    for (int i = 0; i < N_WAY; i++) begin
      k_pre[i] = ka;
      j_pre[i] = ja;
      ka = ka + CNT_BITS'(fl_if.dis_req[i]);
      ja = ja + CNT_BITS'(fl_if.retire_valid[i]);
    end
    r_cnt = ja;
  end

  always_comb begin
    g_cnt = '0;
    for (int i = 0; i < N_WAY; i++) g_cnt = g_cnt + CNT_BITS'(grant[i]);
  end

  // Free slots left after this cycle's grants; retires beyond it are dropped
  assign room  = CNT_BITS'(D) - cnt_q + g_cnt;
  assign r_eff = (r_cnt > room) ? room : r_cnt;

  for (genvar i = 0; i < N_WAY; i++) begin : g_lane
    free_list_lane #(
      .PTR_BITS (PTR_BITS),
      .CNT_BITS (CNT_BITS)
    ) u_lane (
      .req_i    (fl_if.dis_req[i]),
      .ret_i    (fl_if.retire_valid[i]),
      .k_i      (k_pre[i]),
      .j_i      (j_pre[i]),
      .head_i   (head_q),
      .tail_i   (tail_q),
      .cnt_i    (cnt_q),
      .room_i   (room),
      .block_i  (block),
      .grant_o  (grant[i]),
      .rd_idx_o (rd_idx[i]),
      .wr_en_o  (wr_en[i]),
      .wr_idx_o (wr_idx[i])
    );
    assign fl_if.pr_freelist[i] = entries_q[rd_idx[i]];
  end

  assign fl_if.pr_valid   = grant;
  assign fl_if.avail      = (cnt_q >= CNT_BITS'(N_WAY)) ? AV_BITS'(N_WAY)
                                                        : cnt_q[AV_BITS-1:0];
  assign fl_if.free_count = cnt_q;
  assign fl_if.error      = err_q;

  always_comb begin
    entries_d = entries_q;
    for (int i = 0; i < N_WAY; i++)
      if (wr_en[i]) entries_d[wr_idx[i]] = fl_if.retire_pr[i];
    tail_d = tail_q + r_eff[PTR_BITS-1:0];
    err_d  = err_q || (r_cnt > room);
    // Squashed tags still sit between the new tail and the old head, so
    // rewinding head to tail reclaims all of them at once.
    if (fl_if.flush) begin
      head_d = tail_d;
      cnt_d  = CNT_BITS'(D);
    end else begin
      head_d = head_q + g_cnt[PTR_BITS-1:0];
      cnt_d  = cnt_q - g_cnt + r_eff;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < D; i++) entries_q[i] <= CDB_BITS'(ARCH_COUNT + i);
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= CNT_BITS'(D);
      err_q  <= 1'b0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end
endmodule
